regfile_access_ctrl: RTL and testbench

//  Initiator side of the 16x16 register-file port: the datapath's single master for ReadReg1/ReadReg2/WriteReg/WriteData/RegWrite.

---
 rtl/regfile_access_ctrl.sv | 171 +++++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Register-file initiator: serialises operand fetch and write-back,
// tracks pending destinations and stalls reads on RAW/WAW hazards.
module regfile_access_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int NREGS  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_rs,
   input  logic [ADDR_W-1:0] rd_rt,
   input  logic [ADDR_W-1:0] rd_dst,
   input  logic              rd_dst_en,
   output logic              rd_rdy,
   output logic              rd_ack,
   output logic [DATA_W-1:0] OpA,
   output logic [DATA_W-1:0] OpB,
   input  logic              wb_req,
   input  logic [ADDR_W-1:0] wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   output logic              wb_rdy,
   output logic              wb_ack,
   output logic [NREGS-1:0]  busy,
   output logic              stall,
   output logic [ADDR_W-1:0] ReadReg1,
   output logic [ADDR_W-1:0] ReadReg2,
   output logic [ADDR_W-1:0] WriteReg,
   output logic [DATA_W-1:0] WriteData,
   output logic              RegWrite,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B
);

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      WRITE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rs_q, rs_d;
   logic [ADDR_W-1:0] rt_q, rt_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic              dst_en_q, dst_en_d;
   logic              pend_q, pend_d;
   logic [ADDR_W-1:0] wreg_q, wreg_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [NREGS-1:0]  busy_q, busy_d;
   logic [DATA_W-1:0] opa_q, opa_d;
   logic [DATA_W-1:0] opb_q, opb_d;
   logic              rd_ack_q, rd_ack_d;
   logic              wb_ack_q, wb_ack_d;
   logic              regwr_q, regwr_d;
   logic              hazard;

   // Hazard on the latched read: a source or the claimed destination is pending
   always_comb begin
      hazard = busy_q[rs_q] | busy_q[rt_q] | (dst_en_q & busy_q[dst_q]);
   end

   // Next-state and registered-output computation
   always_comb begin
      state_d  = state_q;
      rs_d     = rs_q;
      rt_d     = rt_q;
      dst_d    = dst_q;
      dst_en_d = dst_en_q;
      pend_d   = pend_q;
      wreg_d   = wreg_q;
      wdata_d  = wdata_q;
      busy_d   = busy_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      rd_ack_d = 1'b0;
      wb_ack_d = 1'b0;
      regwr_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (wb_req) begin
               wreg_d  = wb_reg;
               wdata_d = wb_data;
               regwr_d = 1'b1;
               state_d = WRITE;
            end else if (rd_req) begin
               rs_d     = rd_rs;
               rt_d     = rd_rt;
               dst_d    = rd_dst;
               dst_en_d = rd_dst_en;
               pend_d   = 1'b1;
               state_d  = CHECK;
            end
         end
         CHECK: begin
            if (wb_req) begin
               wreg_d  = wb_reg;
               wdata_d = wb_data;
               regwr_d = 1'b1;
               state_d = WRITE;
            end else if (!hazard) begin
               opa_d    = A;
               opb_d    = B;
               if (dst_en_q) begin
                  busy_d[dst_q] = 1'b1;
               end
               rd_ack_d = 1'b1;
               pend_d   = 1'b0;
               state_d  = IDLE;
            end
         end
         WRITE: begin
            busy_d[wreg_q] = 1'b0;
            wb_ack_d       = 1'b1;
            state_d        = pend_q ? CHECK : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rs_q     <= '0;
         rt_q     <= '0;
         dst_q    <= '0;
         dst_en_q <= 1'b0;
         pend_q   <= 1'b0;
         wreg_q   <= '0;
         wdata_q  <= '0;
         busy_q   <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         rd_ack_q <= 1'b0;
         wb_ack_q <= 1'b0;
         regwr_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rs_q     <= rs_d;
         rt_q     <= rt_d;
         dst_q    <= dst_d;
         dst_en_q <= dst_en_d;
         pend_q   <= pend_d;
         wreg_q   <= wreg_d;
         wdata_q  <= wdata_d;
         busy_q   <= busy_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         rd_ack_q <= rd_ack_d;
         wb_ack_q <= wb_ack_d;
         regwr_q  <= regwr_d;
      end
   end

   assign rd_rdy    = (state_q == IDLE) & ~wb_req;
   assign wb_rdy    = (state_q == IDLE) | (state_q == CHECK);
   assign stall     = (state_q == CHECK) & hazard;
   assign rd_ack    = rd_ack_q;
   assign wb_ack    = wb_ack_q;
   assign OpA       = opa_q;
   assign OpB       = opb_q;
   assign busy      = busy_q;
   assign ReadReg1  = rs_q;
   assign ReadReg2  = rt_q;
   assign WriteReg  = wreg_q;
   assign WriteData = wdata_q;
   assign RegWrite  = regwr_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: transaction model plus register file,
// per-cycle output compare and directed hazard/reset scenarios.
module tb_regfile_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_req, rd_dst_en, wb_req;
   logic [3:0]  rd_rs, rd_rt, rd_dst, wb_reg;
   logic [15:0] wb_data;
   logic        rd_rdy, rd_ack, wb_rdy, wb_ack, stall, RegWrite;
   logic [15:0] OpA, OpB, WriteData, A, B, busy;
   logic [3:0]  ReadReg1, ReadReg2, WriteReg;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   regfile_access_ctrl dut (
      .clk(clk), .rst(rst),
      .rd_req(rd_req), .rd_rs(rd_rs), .rd_rt(rd_rt),
      .rd_dst(rd_dst), .rd_dst_en(rd_dst_en),
      .rd_rdy(rd_rdy), .rd_ack(rd_ack), .OpA(OpA), .OpB(OpB),
      .wb_req(wb_req), .wb_reg(wb_reg), .wb_data(wb_data),
      .wb_rdy(wb_rdy), .wb_ack(wb_ack), .busy(busy), .stall(stall),
      .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
      .WriteReg(WriteReg), .WriteData(WriteData),
      .RegWrite(RegWrite), .A(A), .B(B)
   );

   // register file: power-on Ri=i, commits on negedge
   logic [15:0] rf [16];
   bit rf_init = 1'b0;
   always @(negedge clk) begin
      if (!rf_init) begin
         for (int i = 0; i < 16; i++) rf[i] <= 16'(i);
         rf_init <= 1'b1;
      end else if (RegWrite) begin
         rf[WriteReg] <= WriteData;
      end
   end
   assign A = rf[ReadReg1];
   assign B = rf[ReadReg2];

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endfunction

   // transaction model
   bit          m_writing, m_have_rd, m_dst_en;
   bit          m_busy [16];
   logic [3:0]  m_rs, m_rt, m_dst, e_wreg;
   logic [15:0] e_wdata, e_opa, e_opb;
   bit          e_rd_ack, e_wb_ack, e_regwrite;

   function automatic bit m_hazard();
      return m_busy[m_rs] | m_busy[m_rt] | (m_dst_en & m_busy[m_dst]);
   endfunction

   function automatic logic [15:0] m_busy_vec();
      logic [15:0] v;
      v = '0;
      for (int i = 0; i < 16; i++) if (m_busy[i]) v = v | (16'h1 << i);
      return v;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_writing = 0; m_have_rd = 0; m_dst_en = 0;
         for (int i = 0; i < 16; i++) m_busy[i] = 0;
         m_rs = 0; m_rt = 0; m_dst = 0; e_wreg = 0;
         e_wdata = 0; e_opa = 0; e_opb = 0;
         e_rd_ack = 0; e_wb_ack = 0; e_regwrite = 0;
      end else begin
         e_rd_ack = 0;
         e_wb_ack = 0;
         if (m_writing) begin
            m_busy[e_wreg] = 0;
            e_wb_ack = 1;
            e_regwrite = 0;
            m_writing = 0;
         end else if (wb_req) begin
            e_wreg = wb_reg;
            e_wdata = wb_data;
            e_regwrite = 1;
            m_writing = 1;
         end else if (m_have_rd) begin
            if (!m_hazard()) begin
               e_opa = rf[m_rs];
               e_opb = rf[m_rt];
               if (m_dst_en) m_busy[m_dst] = 1;
               e_rd_ack = 1;
               m_have_rd = 0;
            end
         end else if (rd_req) begin
            m_rs = rd_rs;
            m_rt = rd_rt;
            m_dst = rd_dst;
            m_dst_en = rd_dst_en;
            m_have_rd = 1;
         end
      end
   end

   // per-cycle compare against the model
   always @(negedge clk) begin
      chk("rd_rdy", 32'(rd_rdy), 32'(!m_writing && !m_have_rd && !wb_req));
      chk("wb_rdy", 32'(wb_rdy), 32'(!m_writing));
      chk("stall", 32'(stall), 32'(!m_writing && m_have_rd && m_hazard()));
      chk("rd_ack", 32'(rd_ack), 32'(e_rd_ack));
      chk("wb_ack", 32'(wb_ack), 32'(e_wb_ack));
      chk("RegWrite", 32'(RegWrite), 32'(e_regwrite));
      chk("WriteReg", 32'(WriteReg), 32'(e_wreg));
      chk("WriteData", 32'(WriteData), 32'(e_wdata));
      chk("ReadReg1", 32'(ReadReg1), 32'(m_rs));
      chk("ReadReg2", 32'(ReadReg2), 32'(m_rt));
      chk("OpA", 32'(OpA), 32'(e_opa));
      chk("OpB", 32'(OpB), 32'(e_opb));
      chk("busy", 32'(busy), 32'(m_busy_vec()));
   end

   task automatic rd_op(input logic [3:0] rs, rt, dst, input logic en);
      int t;
      @(posedge clk); #1;
      rd_rs = rs; rd_rt = rt; rd_dst = dst; rd_dst_en = en; rd_req = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!rd_rdy && t < 40);
      if (!rd_rdy) chk("rd accept timeout", 0, 1);
      @(posedge clk); #1;
      rd_req = 1'b0;
   endtask

   task automatic wb_op(input logic [3:0] r, input logic [15:0] d);
      int t;
      @(posedge clk); #1;
      wb_reg = r; wb_data = d; wb_req = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!wb_rdy && t < 40);
      if (!wb_rdy) chk("wb accept timeout", 0, 1);
      @(posedge clk); #1;
      wb_req = 1'b0;
      @(negedge clk);
      chk("lit RegWrite", 32'(RegWrite), 1);
      chk("lit WriteReg", 32'(WriteReg), 32'(r));
      chk("lit WriteData", 32'(WriteData), 32'(d));
      @(negedge clk);
      chk("lit wb_ack", 32'(wb_ack), 1);
   endtask

   task automatic wait_ack(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rd_ack && n < 40);
      if (!rd_ack) chk("rd_ack timeout", 0, 1);
   endtask

   initial begin
      int n;
      int t;
      rst = 1'b1;
      rd_req = 0; rd_rs = 0; rd_rt = 0; rd_dst = 0; rd_dst_en = 0;
      wb_req = 0; wb_reg = 0; wb_data = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset busy", 32'(busy), 0);
      chk("reset OpA", 32'(OpA), 0);
      chk("reset RegWrite", 32'(RegWrite), 0);

      // 1 plain read at power-on values
      rd_op(4'd2, 4'd4, 4'd0, 1'b0);
      wait_ack(n);
      chk("t1 latency", 32'(n), 2);
      chk("t1 OpA", 32'(OpA), 2);
      chk("t1 OpB", 32'(OpB), 4);
      chk("t1 model OpA", 32'(e_opa), 2);
      chk("t1 busy", 32'(busy), 0);

      // 2 write then read back
      wb_op(4'd2, 16'h0001);
      rd_op(4'd2, 4'd0, 4'd0, 1'b0);
      wait_ack(n);
      chk("t2 OpA", 32'(OpA), 32'h0001);
      chk("t2 OpB", 32'(OpB), 0);

      // 3 RAW stall released by write-back
      rd_op(4'd1, 4'd3, 4'd5, 1'b1);
      wait_ack(n);
      chk("t3 busy set", 32'(busy), 32'h0020);
      chk("t3 OpA", 32'(OpA), 1);
      rd_op(4'd5, 4'd0, 4'd0, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk("t3 stall", 32'(stall), 1);
         chk("t3 no ack", 32'(rd_ack), 0);
      end
      wb_op(4'd5, 16'hBEEF);
      chk("t3 busy clr", 32'(busy), 0);
      wait_ack(n);
      chk("t3 ack next", 32'(n), 1);
      chk("t3 OpA", 32'(OpA), 32'hBEEF);

      // 4 simultaneous read and write in IDLE
      @(posedge clk); #1;
      rd_rs = 4'd3; rd_rt = 4'd2; rd_dst = 0; rd_dst_en = 0; rd_req = 1;
      wb_reg = 4'd3; wb_data = 16'h1234; wb_req = 1;
      @(negedge clk);
      chk("t4 rd_rdy low", 32'(rd_rdy), 0);
      chk("t4 wb_rdy", 32'(wb_rdy), 1);
      @(posedge clk); #1;
      wb_req = 0;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!rd_rdy && t < 40);
      chk("t4 rd after wb_ack", 32'(wb_ack), 1);
      @(posedge clk); #1;
      rd_req = 0;
      wait_ack(n);
      chk("t4 OpA", 32'(OpA), 32'h1234);
      chk("t4 OpB", 32'(OpB), 32'h0001);

      // 5 WAW on R7
      rd_op(4'd0, 4'd0, 4'd7, 1'b1);
      wait_ack(n);
      chk("t5 busy7", 32'(busy), 32'h0080);
      rd_op(4'd1, 4'd2, 4'd7, 1'b1);
      repeat (3) begin
         @(negedge clk);
         chk("t5 stall", 32'(stall), 1);
      end
      wb_op(4'd7, 16'h0777);
      wait_ack(n);
      chk("t5 busy7 again", 32'(busy), 32'h0080);
      chk("t5 OpA", 32'(OpA), 1);
      chk("t5 OpB", 32'(OpB), 1);

      // register 0 is an ordinary register
      wb_op(4'd0, 16'hA5A5);
      rd_op(4'd0, 4'd15, 4'd0, 1'b0);
      wait_ack(n);
      chk("r0 OpA", 32'(OpA), 32'hA5A5);
      chk("r0 OpB", 32'(OpB), 15);

      // 6 reset while stalled
      rd_op(4'd7, 4'd0, 4'd0, 1'b0);
      @(negedge clk);
      chk("t6 stall", 32'(stall), 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("t6 busy", 32'(busy), 0);
      chk("t6 OpA", 32'(OpA), 0);
      chk("t6 OpB", 32'(OpB), 0);
      chk("t6 idle", 32'(rd_rdy), 1);
      chk("t6 stall", 32'(stall), 0);
      repeat (8) begin
         @(negedge clk);
         chk("t6 no ack", 32'(rd_ack), 0);
      end

      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
